// File: rtl/id_decode_stage_if.sv
// Fetch-to-decode and decode-to-rename handshake bundle for the RV32I decode stage.
// The stage is the slave; the fetch queue / downstream logic side is the master.
interface id_decode_stage_if #(
    parameter int INST_WIDTH         = 32,
    parameter int PC_WIDTH           = 32,
    parameter int ARCH_REG_NUM_WIDTH = 5,
    parameter int IMM_WIDTH          = 32
) ();
    logic                          in_valid;
    logic                          in_ready;
    logic [INST_WIDTH-1:0]         in_inst;
    logic [PC_WIDTH-1:0]           in_pc;
    logic                          out_valid;
    logic                          out_ready;
    logic [PC_WIDTH-1:0]           out_pc;
    logic [6:0]                    out_opcode;
    logic [2:0]                    out_funct3;
    logic [6:0]                    out_funct7;
    logic [ARCH_REG_NUM_WIDTH-1:0] out_rs1;
    logic [ARCH_REG_NUM_WIDTH-1:0] out_rs2;
    logic [ARCH_REG_NUM_WIDTH-1:0] out_rd;
    logic [IMM_WIDTH-1:0]          out_imm;
    logic                          out_uses_rs1;
    logic                          out_uses_rs2;
    logic                          out_writes_rd;
    logic                          out_illegal;

    modport slave (
        input  in_valid, in_inst, in_pc, out_ready,
        output in_ready, out_valid, out_pc, out_opcode, out_funct3, out_funct7,
               out_rs1, out_rs2, out_rd, out_imm, out_uses_rs1, out_uses_rs2,
               out_writes_rd, out_illegal
    );

    modport master (
        output in_valid, in_inst, in_pc, out_ready,
        input  in_ready, out_valid, out_pc, out_opcode, out_funct3, out_funct7,
               out_rs1, out_rs2, out_rd, out_imm, out_uses_rs1, out_uses_rs2,
               out_writes_rd, out_illegal
    );
endinterface

// File: rtl/id_decode_stage.sv
// RV32I decode stage: combinational format/immediate decode feeding a 2-entry
// registered skid buffer so both handshakes stay fully registered at 1 inst/cycle.
module id_decode_stage #(
    parameter int INST_WIDTH         = 32,
    parameter int PC_WIDTH           = 32,
    parameter int ARCH_REG_NUM_WIDTH = 5,
    parameter int IMM_WIDTH          = 32
) (
    input logic               clk,
    input logic               rst_n,
    input logic               flush,
    id_decode_stage_if.slave  bus
);

    typedef struct packed {
        logic [PC_WIDTH-1:0]           pc;
        logic [6:0]                    opcode;
        logic [2:0]                    funct3;
        logic [6:0]                    funct7;
        logic [ARCH_REG_NUM_WIDTH-1:0] rs1;
        logic [ARCH_REG_NUM_WIDTH-1:0] rs2;
        logic [ARCH_REG_NUM_WIDTH-1:0] rd;
        logic [IMM_WIDTH-1:0]          imm;
        logic                          usesRs1;
        logic                          usesRs2;
        logic                          writesRd;
        logic                          illegal;
    } entry_t;

    typedef enum logic [1:0] {EMPTY, ONE, TWO} state_t;
    typedef enum logic [2:0] {FMT_R, FMT_I, FMT_S, FMT_B, FMT_U, FMT_J, FMT_BAD} fmt_t;

    fmt_t        w_fmt;
    logic [31:0] w_inst;
    logic [31:0] w_imm32;
    entry_t      w_decoded;

    state_t      r_state;
    state_t      w_nextState;
    logic        r_inReady;
    entry_t      r_head;
    entry_t      r_tail;
    logic        w_accept;
    logic        w_pop;
    logic        w_loadHead;
    logic        w_loadTail;
    logic        w_shift;

    assign w_inst = bus.in_inst[31:0];

    always_comb begin
        w_fmt = FMT_BAD;
        case (w_inst[6:0])
            7'b0010011, 7'b0000011, 7'b1100111: w_fmt = FMT_I;
            7'b0100011:                         w_fmt = FMT_S;
            7'b1100011:                         w_fmt = FMT_B;
            7'b0110111, 7'b0010111:             w_fmt = FMT_U;
            7'b1101111:                         w_fmt = FMT_J;
            7'b0110011:                         w_fmt = FMT_R;
            default:                            w_fmt = FMT_BAD;
        endcase
    end

    always_comb begin
        w_imm32 = '0;
        case (w_fmt)
            FMT_I:   w_imm32 = {{20{w_inst[31]}}, w_inst[31:20]};
            FMT_S:   w_imm32 = {{20{w_inst[31]}}, w_inst[31:25], w_inst[11:7]};
            FMT_B:   w_imm32 = {{20{w_inst[31]}}, w_inst[7], w_inst[30:25], w_inst[11:8], 1'b0};
            FMT_U:   w_imm32 = {w_inst[31:12], 12'b0};
            FMT_J:   w_imm32 = {{12{w_inst[31]}}, w_inst[19:12], w_inst[20], w_inst[30:21], 1'b0};
            default: w_imm32 = '0;
        endcase
    end

    // Raw fields pass through even for unrecognised opcodes; only the derived info is zeroed.
    always_comb begin
        w_decoded          = '0;
        w_decoded.pc       = bus.in_pc;
        w_decoded.opcode   = w_inst[6:0];
        w_decoded.funct3   = w_inst[14:12];
        w_decoded.funct7   = w_inst[31:25];
        w_decoded.rs1      = ARCH_REG_NUM_WIDTH'(w_inst[19:15]);
        w_decoded.rs2      = ARCH_REG_NUM_WIDTH'(w_inst[24:20]);
        w_decoded.rd       = ARCH_REG_NUM_WIDTH'(w_inst[11:7]);
        w_decoded.imm      = {{(IMM_WIDTH-31){w_imm32[31]}}, w_imm32[30:0]};
        w_decoded.usesRs1  = (w_fmt == FMT_R) || (w_fmt == FMT_I) || (w_fmt == FMT_S) || (w_fmt == FMT_B);
        w_decoded.usesRs2  = (w_fmt == FMT_R) || (w_fmt == FMT_S) || (w_fmt == FMT_B);
        w_decoded.writesRd = ((w_fmt == FMT_R) || (w_fmt == FMT_I) || (w_fmt == FMT_U) || (w_fmt == FMT_J))
                             && (w_inst[11:7] != 5'd0);
        w_decoded.illegal  = (w_fmt == FMT_BAD);
    end

    assign w_accept = bus.in_valid && r_inReady;
    assign w_pop    = (r_state != EMPTY) && bus.out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= EMPTY;
            r_inReady <= 1'b1;
        end else begin
            r_state   <= w_nextState;
            r_inReady <= (w_nextState != TWO);
        end
    end

    // Flush wins over both handshakes; in ONE an accept+pop overwrites the head in place.
    always_comb begin
        w_nextState = r_state;
        w_loadHead  = 1'b0;
        w_loadTail  = 1'b0;
        w_shift     = 1'b0;
        if (flush) begin
            w_nextState = EMPTY;
        end else begin
            case (r_state)
                EMPTY: begin
                    if (w_accept) begin
                        w_nextState = ONE;
                        w_loadHead  = 1'b1;
                    end
                end
                ONE: begin
                    if (w_accept && w_pop) begin
                        w_loadHead  = 1'b1;
                    end else if (w_accept) begin
                        w_nextState = TWO;
                        w_loadTail  = 1'b1;
                    end else if (w_pop) begin
                        w_nextState = EMPTY;
                    end
                end
                TWO: begin
                    if (w_pop) begin
                        w_nextState = ONE;
                        w_shift     = 1'b1;
                    end
                end
                default: w_nextState = EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_head <= '0;
            r_tail <= '0;
        end else begin
            if (w_loadHead) r_head <= w_decoded;
            else if (w_shift) r_head <= r_tail;
            if (w_loadTail) r_tail <= w_decoded;
        end
    end

    assign bus.in_ready      = r_inReady;
    assign bus.out_valid     = (r_state != EMPTY);
    assign bus.out_pc        = r_head.pc;
    assign bus.out_opcode    = r_head.opcode;
    assign bus.out_funct3    = r_head.funct3;
    assign bus.out_funct7    = r_head.funct7;
    assign bus.out_rs1       = r_head.rs1;
    assign bus.out_rs2       = r_head.rs2;
    assign bus.out_rd        = r_head.rd;
    assign bus.out_imm       = r_head.imm;
    assign bus.out_uses_rs1  = r_head.usesRs1;
    assign bus.out_uses_rs2  = r_head.usesRs2;
    assign bus.out_writes_rd = r_head.writesRd;
    assign bus.out_illegal   = r_head.illegal;

endmodule

// File: tb/tb_id_decode_stage.sv
// Self-checking bench for id_decode_stage: directed vector table, hand-written
// backpressure/flush/async-reset sequences, and random traffic against a queue model.
module tb_id_decode_stage;

    logic clk;
    logic rst_n;
    logic flush;

    id_decode_stage_if #(.INST_WIDTH(32), .PC_WIDTH(32), .ARCH_REG_NUM_WIDTH(5), .IMM_WIDTH(32)) bus ();

    id_decode_stage #(.INST_WIDTH(32), .PC_WIDTH(32), .ARCH_REG_NUM_WIDTH(5), .IMM_WIDTH(32)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .flush (flush),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] pc;
        logic [6:0]  opcode;
        logic [2:0]  funct3;
        logic [6:0]  funct7;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic [31:0] imm;
        logic        usesRs1;
        logic        usesRs2;
        logic        writesRd;
        logic        illegal;
    } decoded_t;

    typedef struct {
        logic [31:0] inst;
        logic [31:0] imm;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic        usesRs1;
        logic        usesRs2;
        logic        writesRd;
        logic        illegal;
    } vec_t;

    int       errors = 0;
    int       checks = 0;
    decoded_t modelQ[$];
    logic [31:0] pcNext = 32'h0000_1000;

    // Reference decode: immediates rebuilt as signed integer sums of their bit fields.
    function automatic decoded_t refDecode(input logic [31:0] inst, input logic [31:0] pc);
        decoded_t d;
        int       v;
        logic     fR, fI, fS, fB, fU, fJ;
        d = '0;
        d.pc = pc; d.opcode = inst[6:0]; d.funct3 = inst[14:12]; d.funct7 = inst[31:25];
        d.rs1 = inst[19:15]; d.rs2 = inst[24:20]; d.rd = inst[11:7];
        fR = (inst[6:0] == 7'h33);
        fI = (inst[6:0] == 7'h13) || (inst[6:0] == 7'h03) || (inst[6:0] == 7'h67);
        fS = (inst[6:0] == 7'h23);
        fB = (inst[6:0] == 7'h63);
        fU = (inst[6:0] == 7'h37) || (inst[6:0] == 7'h17);
        fJ = (inst[6:0] == 7'h6F);
        v = 0;
        if (fI) v = int'(inst[31:20]) - (inst[31] ? 4096 : 0);
        if (fS) v = int'(inst[31:25]) * 32 + int'(inst[11:7]) - (inst[31] ? 4096 : 0);
        if (fB) v = int'(inst[7]) * 2048 + int'(inst[30:25]) * 32 + int'(inst[11:8]) * 2 - (inst[31] ? 4096 : 0);
        if (fJ) v = int'(inst[19:12]) * 4096 + int'(inst[20]) * 2048 + int'(inst[30:21]) * 2 - (inst[31] ? (1 << 20) : 0);
        if (fU) v = int'(inst & 32'hFFFF_F000);
        d.imm      = 32'(v);
        d.usesRs1  = fR | fI | fS | fB;
        d.usesRs2  = fR | fS | fB;
        d.writesRd = (fR | fI | fU | fJ) && (inst[11:7] != 5'd0);
        d.illegal  = !(fR | fI | fS | fB | fU | fJ);
        return d;
    endfunction

    task automatic compare(input string name, input logic [127:0] actual, input logic [127:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
        end
    endtask

    function automatic decoded_t dutHead();
        decoded_t d;
        d = {bus.out_pc, bus.out_opcode, bus.out_funct3, bus.out_funct7, bus.out_rs1, bus.out_rs2,
             bus.out_rd, bus.out_imm, bus.out_uses_rs1, bus.out_uses_rs2, bus.out_writes_rd, bus.out_illegal};
        return d;
    endfunction

    // Drive one cycle of inputs, advance the model, then sample #1 after the edge.
    task automatic applyStimulus(input logic valid, input logic [31:0] inst, input logic ready, input logic fl);
        int  sz;
        logic acc, pop;
        bus.in_valid  = valid;
        bus.in_inst   = inst;
        bus.in_pc     = pcNext;
        bus.out_ready = ready;
        flush         = fl;
        sz  = modelQ.size();
        acc = valid && (sz < 2);
        pop = ready && (sz > 0);
        if (fl) begin
            modelQ.delete();
        end else begin
            if (pop) void'(modelQ.pop_front());
            if (acc) modelQ.push_back(refDecode(inst, pcNext));
        end
        pcNext = pcNext + 32'd4;
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name);
        compare({name, ".out_valid"}, 128'(bus.out_valid), 128'(modelQ.size() > 0));
        compare({name, ".in_ready"}, 128'(bus.in_ready), 128'(modelQ.size() < 2));
        if (modelQ.size() > 0)
            compare({name, ".head"}, 128'(dutHead()), 128'(modelQ[0]));
    endtask

    vec_t vecs[8];

    initial begin
        vecs[0] = '{32'hFFF10093, 32'hFFFFFFFF, 5'd2,  5'd31, 5'd1,  1'b1, 1'b0, 1'b1, 1'b0};
        vecs[1] = '{32'h00532423, 32'h00000008, 5'd6,  5'd5,  5'd8,  1'b1, 1'b1, 1'b0, 1'b0};
        vecs[2] = '{32'h123451B7, 32'h12345000, 5'd8,  5'd3,  5'd3,  1'b0, 1'b0, 1'b1, 1'b0};
        vecs[3] = '{32'hFFDFF0EF, 32'hFFFFFFFC, 5'd31, 5'd29, 5'd1,  1'b0, 1'b0, 1'b1, 1'b0};
        vecs[4] = '{32'h0000007F, 32'h00000000, 5'd0,  5'd0,  5'd0,  1'b0, 1'b0, 1'b0, 1'b1};
        vecs[5] = '{32'h00000013, 32'h00000000, 5'd0,  5'd0,  5'd0,  1'b1, 1'b0, 1'b0, 1'b0};
        vecs[6] = '{32'h002081B3, 32'h00000000, 5'd1,  5'd2,  5'd3,  1'b1, 1'b1, 1'b1, 1'b0};
        vecs[7] = '{32'hFE208CE3, 32'hFFFFFFF8, 5'd1,  5'd2,  5'd25, 1'b1, 1'b1, 1'b0, 1'b0};

        rst_n = 1'b0;
        flush = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_inst   = '0;
        bus.in_pc     = '0;
        bus.out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        compare("reset.out_valid", 128'(bus.out_valid), 128'(0));
        compare("reset.in_ready", 128'(bus.in_ready), 128'(1));
        compare("reset.data", 128'(dutHead()), 128'(0));
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        $display("[TB] directed vectors");
        foreach (vecs[i]) begin
            applyStimulus(1'b1, vecs[i].inst, 1'b1, 1'b0);
            checkOutput($sformatf("vec%0d", i));
            compare($sformatf("vec%0d.fields", i),
                    128'({bus.out_valid, bus.out_imm, bus.out_rs1, bus.out_rs2, bus.out_rd,
                          bus.out_uses_rs1, bus.out_uses_rs2, bus.out_writes_rd, bus.out_illegal}),
                    128'({1'b1, vecs[i].imm, vecs[i].rs1, vecs[i].rs2, vecs[i].rd,
                          vecs[i].usesRs1, vecs[i].usesRs2, vecs[i].writesRd, vecs[i].illegal}));
        end
        applyStimulus(1'b0, 32'h0, 1'b1, 1'b0);
        checkOutput("drain");

        $display("[TB] backpressure A,B,C");
        applyStimulus(1'b1, 32'h00100093, 1'b0, 1'b0);
        checkOutput("bp.A");
        applyStimulus(1'b1, 32'h00200113, 1'b0, 1'b0);
        checkOutput("bp.B");
        compare("bp.full_in_ready", 128'(bus.in_ready), 128'(0));
        applyStimulus(1'b1, 32'h00300193, 1'b0, 1'b0);
        checkOutput("bp.C_blocked");
        compare("bp.head_is_A", 128'(bus.out_rd), 128'(1));
        applyStimulus(1'b1, 32'h00300193, 1'b1, 1'b0);
        checkOutput("bp.popA");
        compare("bp.head_is_B", 128'(bus.out_rd), 128'(2));
        applyStimulus(1'b1, 32'h00300193, 1'b1, 1'b0);
        checkOutput("bp.popB");
        compare("bp.head_is_C", 128'(bus.out_rd), 128'(3));
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b1, 32'h00000213 | (32'(i) << 20), 1'b1, 1'b0);
            checkOutput($sformatf("bp.stream%0d", i));
        end

        $display("[TB] flush with two entries held");
        applyStimulus(1'b1, 32'h00500293, 1'b0, 1'b0);
        applyStimulus(1'b1, 32'h00600313, 1'b0, 1'b0);
        checkOutput("flush.pre");
        applyStimulus(1'b1, 32'h00700393, 1'b1, 1'b1);
        checkOutput("flush.post");
        compare("flush.out_valid", 128'(bus.out_valid), 128'(0));
        compare("flush.in_ready", 128'(bus.in_ready), 128'(1));
        applyStimulus(1'b1, 32'h00800413, 1'b1, 1'b0);
        checkOutput("flush.next");
        compare("flush.next_rd", 128'(bus.out_rd), 128'(8));

        $display("[TB] async reset with two entries held");
        applyStimulus(1'b1, 32'h00900493, 1'b0, 1'b0);
        applyStimulus(1'b1, 32'h00A00513, 1'b0, 1'b0);
        checkOutput("areset.pre");
        bus.in_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        compare("areset.out_valid", 128'(bus.out_valid), 128'(0));
        compare("areset.in_ready", 128'(bus.in_ready), 128'(1));
        compare("areset.data", 128'(dutHead()), 128'(0));
        modelQ.delete();
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("areset.idle");
        applyStimulus(1'b1, 32'h00B00593, 1'b1, 1'b0);
        checkOutput("areset.new");
        compare("areset.new_rd", 128'(bus.out_rd), 128'(11));

        $display("[TB] random traffic");
        for (int i = 0; i < 400; i++) begin
            logic [31:0] inst;
            logic [6:0]  ops[10];
            ops = '{7'h13, 7'h03, 7'h67, 7'h23, 7'h63, 7'h37, 7'h17, 7'h6F, 7'h33, 7'h00};
            inst = $urandom;
            if ($urandom_range(0, 9) != 0) inst[6:0] = ops[$urandom_range(0, 8)];
            applyStimulus($urandom_range(0, 9) < 7, inst, $urandom_range(0, 9) < 6,
                          $urandom_range(0, 19) == 0);
            checkOutput($sformatf("rand%0d", i));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
